// File: rtl/iob_fifo_sync_asym_fwft_pkg.sv
// Width helpers shared by the asymmetric FIFO top and its slot memory.
// Pure functions, no logic.
package iob_fifo_sync_asym_fwft_pkg;

    function automatic int min_w(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

endpackage

// File: rtl/iob_fifo_asym_mem.sv
// Flop array of MIN_W-bit slots: WR-slot aligned write port, RR-slot combinational read port.
// Write latency 1 cycle, read is combinational; no backpressure (caller gates w_en).
// Contents are deliberately left unreset.
module iob_fifo_asym_mem
    import iob_fifo_sync_asym_fwft_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [R_DATA_W-1:0] r_data
);

    localparam int MIN_W = min_w(W_DATA_W, R_DATA_W);
    localparam int WR    = W_DATA_W / MIN_W;
    localparam int RR    = R_DATA_W / MIN_W;

    logic [MIN_W-1:0] mem [2**ADDR_W];

    // Little-endian: slice i of a wide word lands in slot base+i.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < WR; i++) begin
                mem[w_addr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
            end
        end
    end

    always_comb begin
        r_data = '0;
        for (int j = 0; j < RR; j++) begin
            r_data[j*MIN_W +: MIN_W] = mem[r_addr + ADDR_W'(j)];
        end
    end

endmodule

// File: rtl/iob_fifo_sync_asym_fwft.sv
// Same-clock width-converting FIFO with FWFT or registered read, level flags and sticky errors.
// Latency: write visible after 1 edge; FWFT=1 data on r_data then, FWFT=0 one edge after r_en.
// Backpressure: w_full/r_empty gate acceptance; rejected requests only set the sticky flags.
module iob_fifo_sync_asym_fwft
    import iob_fifo_sync_asym_fwft_pkg::*;
#(
    parameter int W_DATA_W  = 32,
    parameter int R_DATA_W  = 8,
    parameter int ADDR_W    = 4,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (2**ADDR_W) - max_w(W_DATA_W, R_DATA_W) / min_w(W_DATA_W, R_DATA_W),
    parameter int AEMPTY_TH = max_w(W_DATA_W, R_DATA_W) / min_w(W_DATA_W, R_DATA_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    output logic                w_afull,
    output logic                w_overflow,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic                r_aempty,
    output logic                r_underflow,
    output logic [ADDR_W:0]     level
);

    localparam int MIN_W = min_w(W_DATA_W, R_DATA_W);
    localparam int MAX_W = max_w(W_DATA_W, R_DATA_W);
    localparam int WR    = W_DATA_W / MIN_W;
    localparam int RR    = R_DATA_W / MIN_W;

    localparam logic [ADDR_W:0]   WR_L     = (ADDR_W+1)'(WR);
    localparam logic [ADDR_W:0]   RR_L     = (ADDR_W+1)'(RR);
    localparam logic [ADDR_W:0]   FULL_L   = (ADDR_W+1)'((2**ADDR_W) - WR);
    localparam logic [ADDR_W:0]   AFULL_L  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0]   AEMPTY_L = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W-1:0] WR_P     = ADDR_W'(WR);
    localparam logic [ADDR_W-1:0] RR_P     = ADDR_W'(RR);

    if (!is_pow2(MAX_W / MIN_W) || (MAX_W % MIN_W) != 0 || ADDR_W < $clog2(MAX_W / MIN_W)) begin : g_param_err
        $error("iob_fifo_sync_asym_fwft: width ratio must be a power of 2 and ADDR_W >= log2(ratio)");
    end

    logic [ADDR_W-1:0]   w_ptr, r_ptr;
    logic [ADDR_W:0]     level_q;
    logic                overflow_q, underflow_q;
    logic [R_DATA_W-1:0] r_data_q, mem_rdata;
    logic                w_acc, r_acc;

    assign w_full      = level_q > FULL_L;
    assign r_empty     = level_q < RR_L;
    assign w_afull     = level_q >= AFULL_L;
    assign r_aempty    = level_q <= AEMPTY_L;
    assign w_overflow  = overflow_q;
    assign r_underflow = underflow_q;
    assign level       = level_q;

    // Acceptance uses pre-edge level only, so a same-cycle read never frees room for the write.
    assign w_acc = w_en & ~w_full;
    assign r_acc = r_en & ~r_empty;

    iob_fifo_asym_mem #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .w_en   (w_acc),
        .w_addr (w_ptr),
        .w_data (w_data),
        .r_addr (r_ptr),
        .r_data (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            r_data_q    <= '0;
        end else if (clr) begin
            w_ptr       <= '0;
            r_ptr       <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            r_data_q    <= '0;
        end else begin
            if (w_acc) w_ptr <= w_ptr + WR_P;
            if (r_acc) r_ptr <= r_ptr + RR_P;
            level_q     <= level_q + (w_acc ? WR_L : '0) - (r_acc ? RR_L : '0);
            overflow_q  <= overflow_q | (w_en & w_full);
            underflow_q <= underflow_q | (r_en & r_empty);
            if (r_acc) r_data_q <= mem_rdata;
        end
    end

    assign r_data = (FWFT != 0) ? mem_rdata : r_data_q;

endmodule

// File: tb/tb_iob_fifo_sync_asym_fwft.sv
// Bench for the asymmetric FIFO: a 32->8 registered-read instance and an 8->32 FWFT instance,
// both checked against byte-queue reference models.
module tb_iob_fifo_sync_asym_fwft;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: 32 -> 8, registered read
    logic        a_clr = 0, a_w_en = 0, a_r_en = 0;
    logic [31:0] a_w_data = '0;
    logic        a_w_full, a_w_afull, a_w_overflow, a_r_empty, a_r_aempty, a_r_underflow;
    logic [7:0]  a_r_data;
    logic [4:0]  a_level;

    // Instance B: 8 -> 32, first-word-fall-through
    logic        b_clr = 0, b_w_en = 0, b_r_en = 0;
    logic [7:0]  b_w_data = '0;
    logic        b_w_full, b_w_afull, b_w_overflow, b_r_empty, b_r_aempty, b_r_underflow;
    logic [31:0] b_r_data;
    logic [4:0]  b_level;

    iob_fifo_sync_asym_fwft #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .FWFT(0)) dut_a (
        .clk(clk), .reset(reset), .clr(a_clr),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full), .w_afull(a_w_afull),
        .w_overflow(a_w_overflow), .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty),
        .r_aempty(a_r_aempty), .r_underflow(a_r_underflow), .level(a_level)
    );

    iob_fifo_sync_asym_fwft #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .FWFT(1)) dut_b (
        .clk(clk), .reset(reset), .clr(b_clr),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full), .w_afull(b_w_afull),
        .w_overflow(b_w_overflow), .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty),
        .r_aempty(b_r_aempty), .r_underflow(b_r_underflow), .level(b_level)
    );

    // Reference models: FIFO contents as a queue of bytes (the MIN_W unit), capacity 16.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         a_ovf_m, a_unf_m, a_racc;
    bit         b_ovf_m, b_unf_m;
    logic [7:0] a_rd_m;

    task automatic drive_a(input bit we, input logic [31:0] wd, input bit re, input bit cl);
        bit full, empty;
        full  = qa.size() > 12;
        empty = qa.size() < 1;
        a_w_en = we; a_w_data = wd; a_r_en = re; a_clr = cl;
        a_racc = 0;
        if (cl) begin
            qa.delete(); a_ovf_m = 0; a_unf_m = 0; a_rd_m = 8'h00;
        end else begin
            if (re && !empty) begin a_rd_m = qa.pop_front(); a_racc = 1; end
            else if (re) a_unf_m = 1;
            if (we && !full) for (int k = 0; k < 4; k++) qa.push_back(wd[8*k +: 8]);
            else if (we) a_ovf_m = 1;
        end
        @(posedge clk); #1;
        a_w_en = 0; a_r_en = 0; a_clr = 0;
    endtask

    task automatic drive_b(input bit we, input logic [7:0] wd, input bit re, input bit cl);
        bit full, empty;
        full  = qb.size() > 15;
        empty = qb.size() < 4;
        b_w_en = we; b_w_data = wd; b_r_en = re; b_clr = cl;
        if (cl) begin
            qb.delete(); b_ovf_m = 0; b_unf_m = 0;
        end else begin
            if (re && !empty) for (int k = 0; k < 4; k++) void'(qb.pop_front());
            else if (re) b_unf_m = 1;
            if (we && !full) qb.push_back(wd);
            else if (we) b_ovf_m = 1;
        end
        @(posedge clk); #1;
        b_w_en = 0; b_r_en = 0; b_clr = 0;
    endtask

    task automatic test_reset();
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL reset_a_level got %0d want 0", a_level); end
        checks++; if ({a_w_full, a_w_afull, a_r_empty, a_r_aempty} !== 4'b0011) begin errors++; $display("FAIL reset_a_flags got %b want 0011", {a_w_full, a_w_afull, a_r_empty, a_r_aempty}); end
        checks++; if ({a_w_overflow, a_r_underflow} !== 2'b00) begin errors++; $display("FAIL reset_a_sticky got %b want 00", {a_w_overflow, a_r_underflow}); end
        checks++; if (a_r_data !== 8'h00) begin errors++; $display("FAIL reset_a_rdata got %h want 00", a_r_data); end
        checks++; if (b_level !== 5'd0) begin errors++; $display("FAIL reset_b_level got %0d want 0", b_level); end
        checks++; if ({b_w_full, b_w_afull, b_r_empty, b_r_aempty, b_w_overflow, b_r_underflow} !== 6'b001100) begin errors++; $display("FAIL reset_b_flags got %b want 001100", {b_w_full, b_w_afull, b_r_empty, b_r_aempty, b_w_overflow, b_r_underflow}); end
    endtask

    task automatic test_stream_32to8();
        int wi, ri, cyc;
        bit we, re;
        logic [7:0] b0;
        wi = 0; ri = 0; cyc = 0;
        while (ri < 256 && cyc < 3000) begin
            we = (wi < 64) && (qa.size() <= 12) && ($urandom_range(0, 3) != 0);
            re = (qa.size() >= 1) && ($urandom_range(0, 2) != 0);
            b0 = 8'(4 * wi);
            drive_a(we, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, re, 0);
            if (we) wi++;
            if (a_racc) begin
                checks++; if (a_r_data !== 8'(ri)) begin errors++; $display("FAIL stream_order got %h want %h", a_r_data, 8'(ri)); end
                ri++;
            end
            checks++; if (a_r_data !== a_rd_m) begin errors++; $display("FAIL stream_rdata_hold got %h want %h", a_r_data, a_rd_m); end
            checks++; if (a_level !== 5'(qa.size())) begin errors++; $display("FAIL stream_level got %0d want %0d", a_level, qa.size()); end
            checks++;
            if ({a_w_full, a_w_afull, a_r_empty, a_r_aempty} !== {qa.size() > 12, qa.size() >= 12, qa.size() < 1, qa.size() <= 4}) begin
                errors++; $display("FAIL stream_flags got %b at level %0d", {a_w_full, a_w_afull, a_r_empty, a_r_aempty}, qa.size());
            end
            cyc++;
        end
        checks++; if (ri != 256) begin errors++; $display("FAIL stream_timeout got %0d bytes want 256", ri); end
        checks++; if ({a_w_overflow, a_r_underflow} !== 2'b00) begin errors++; $display("FAIL stream_sticky got %b want 00", {a_w_overflow, a_r_underflow}); end
    endtask

    task automatic test_fwft_8to32();
        drive_b(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            drive_b(1, 8'(i), 0, 0);
            checks++; if (b_r_empty !== (i < 3)) begin errors++; $display("FAIL fwft_empty write%0d got %b want %b", i, b_r_empty, i < 3); end
        end
        checks++; if (b_r_data !== 32'h03020100) begin errors++; $display("FAIL fwft_data got %h want 03020100", b_r_data); end
        checks++; if (b_level !== 5'd4) begin errors++; $display("FAIL fwft_level got %0d want 4", b_level); end
    endtask

    task automatic test_random_8to32();
        bit we, re;
        for (int c = 0; c < 300; c++) begin
            we = (qb.size() <= 15) && ($urandom_range(0, 1) != 0);
            re = (qb.size() >= 4) && ($urandom_range(0, 3) == 0);
            drive_b(we, 8'($urandom), re, 0);
            checks++; if (b_level !== 5'(qb.size())) begin errors++; $display("FAIL b_level got %0d want %0d", b_level, qb.size()); end
            checks++; if ({b_w_full, b_r_empty} !== {qb.size() > 15, qb.size() < 4}) begin errors++; $display("FAIL b_flags got %b at level %0d", {b_w_full, b_r_empty}, qb.size()); end
            if (qb.size() >= 4) begin
                checks++; if (b_r_data !== {qb[3], qb[2], qb[1], qb[0]}) begin errors++; $display("FAIL b_head got %h want %h", b_r_data, {qb[3], qb[2], qb[1], qb[0]}); end
            end
        end
        checks++; if ({b_w_overflow, b_r_underflow} !== 2'b00) begin errors++; $display("FAIL b_sticky got %b want 00", {b_w_overflow, b_r_underflow}); end
    endtask

    task automatic test_overflow();
        drive_a(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive_a(1, $urandom, 0, 0);
        checks++; if ({a_level, a_w_full, a_w_afull} !== {5'd16, 2'b11}) begin errors++; $display("FAIL ovf_full got level %0d full %b afull %b want 16 1 1", a_level, a_w_full, a_w_afull); end
        drive_a(1, 32'hDEADBEEF, 0, 0);
        checks++; if (a_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", a_level); end
        checks++; if (a_w_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", a_w_overflow); end
        for (int i = 0; i < 16; i++) begin
            drive_a(0, 0, 1, 0);
            checks++; if (a_r_data !== a_rd_m) begin errors++; $display("FAIL ovf_data byte%0d got %h want %h", i, a_r_data, a_rd_m); end
        end
        checks++; if (a_w_overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", a_w_overflow); end
    endtask

    task automatic test_underflow();
        drive_a(0, 0, 1, 0);
        checks++; if ({a_r_underflow, a_level} !== {1'b1, 5'd0}) begin errors++; $display("FAIL unf_set got unf %b level %0d want 1 0", a_r_underflow, a_level); end
        drive_a(0, 0, 0, 1);
        checks++; if ({a_w_overflow, a_r_underflow, a_r_data} !== 10'b0) begin errors++; $display("FAIL clr_sticky got ovf %b unf %b rdata %h want 0 0 00", a_w_overflow, a_r_underflow, a_r_data); end
    endtask

    task automatic test_back_to_back();
        drive_a(0, 0, 0, 1);
        drive_a(1, 32'h44332211, 0, 0);
        drive_a(1, 32'h88776655, 0, 0);
        checks++; if (a_level !== 5'd8) begin errors++; $display("FAIL simul_pre got %0d want 8", a_level); end
        drive_a(1, 32'hCCBBAA99, 1, 0);
        checks++; if (a_level !== 5'd11) begin errors++; $display("FAIL simul_level got %0d want 11", a_level); end
        checks++; if (a_r_data !== 8'h11) begin errors++; $display("FAIL simul_data got %h want 11", a_r_data); end
        drive_a(0, 0, 0, 0);
        checks++; if (a_r_data !== 8'h11) begin errors++; $display("FAIL rdata_hold got %h want 11", a_r_data); end
    endtask

    task automatic test_reset_mid();
        drive_a(1, 32'h12345678, 0, 0);
        drive_b(1, 8'h5A, 0, 0);
        drive_a(0, 0, 1, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        qa.delete(); qb.delete();
        a_ovf_m = 0; a_unf_m = 0; b_ovf_m = 0; b_unf_m = 0; a_rd_m = 8'h00;
        #1;
        checks++; if ({a_level, a_r_empty, a_r_aempty, a_w_full, a_w_afull} !== {5'd0, 4'b1100}) begin errors++; $display("FAIL arst_a got level %0d flags %b", a_level, {a_r_empty, a_r_aempty, a_w_full, a_w_afull}); end
        checks++; if (a_r_data !== 8'h00) begin errors++; $display("FAIL arst_a_rdata got %h want 00", a_r_data); end
        checks++; if ({b_level, b_r_empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL arst_b got level %0d empty %b", b_level, b_r_empty); end
        #1 reset = 1'b1;
        drive_a(1, 32'hDDCCBBAA, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive_a(0, 0, 1, 0);
            checks++; if (a_r_data !== a_rd_m) begin errors++; $display("FAIL arst_fresh byte%0d got %h want %h", i, a_r_data, a_rd_m); end
        end
        checks++; if (a_rd_m !== 8'hDD || a_level !== 5'd0) begin errors++; $display("FAIL arst_fresh_end got last %h level %0d want dd 0", a_r_data, a_level); end
    endtask

    task automatic test_wrap();
        int nxt;
        logic [7:0] b0;
        drive_a(0, 0, 0, 1);
        nxt = 0;
        for (int r = 0; r < 10; r++) begin
            for (int w = 0; w < 3; w++) begin
                b0 = 8'(12 * r + 4 * w);
                drive_a(1, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 0, 0);
            end
            for (int k = 0; k < 12; k++) begin
                drive_a(0, 0, 1, 0);
                checks++; if (a_r_data !== 8'(nxt)) begin errors++; $display("FAIL wrap round%0d got %h want %h", r, a_r_data, 8'(nxt)); end
                nxt++;
            end
        end
        checks++; if ({a_level, a_w_overflow, a_r_underflow} !== 7'd0) begin errors++; $display("FAIL wrap_end got level %0d ovf %b unf %b", a_level, a_w_overflow, a_r_underflow); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b1;
        test_stream_32to8();
        test_fwft_8to32();
        test_random_8to32();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
